spu_alu_sched: RTL
==================

# spu_alu_sched

Two-port scheduler that shares the single SPU quadword ALU (128-bit operands, 4-bit ALU control, half/full-word lane select) between two requesters, such as the even and odd issue slots. It arbitrates round-robin, registers the winning operands into the ALU, and waits a fixed multi-cycle latency for multiply. It holds the result with its zero flag in an output register until the consumer takes it. Only one operation is in flight at a time.

## Interface
- DATA_W, 128, operand/result width (quadword)
- TAG_W, 4, requester-supplied tag returned with the result
- MUL_LAT, 4, cycles the ALU is held for op 4'b0111 (multiply); must be ≥1
- clk  in  1  clock; all state on the rising edge
- rst_n  in  1  reset, asynchronous, active-low; one clock domain
- req_valid[1:0]  in  2  per-requester request valid
- req_ready[1:0]  out  2  per-requester accept
- req_a0, req_b0, req_a1, req_b1  in  DATA_W  operands per requester
- req_op0, req_op1  in  4  ALU control code per requester
- req_half0, req_half1  in  1  1 = halfword lanes, 0 = fullword lanes
- req_tag0, req_tag1  in  TAG_W  tag per requester
- alu_a, alu_b  out  DATA_W  registered operands to the ALU
- alu_ctr  out  4  registered control code
- alu_half  out  1  registered lane select
- alu_out  in  DATA_W  ALU result (combinational from alu_* outputs)
- alu_zero  in  1  ALU zero flag
- res_valid  out  1  result valid
- res_ready  in  1  consumer accept
- res_data  out  DATA_W  captured result
- res_zero  out  1  captured zero flag
- res_err  out  1  illegal op code (>4'b1000)
- res_tag  out  TAG_W  tag of the completed op
- res_src  out  1  requester index of the completed op

## Operation
- States: IDLE, EXEC, HOLD.
- IDLE:
  - req_ready[i] = grant[i] only; the grant is combinational from req_valid and the priority pointer.
  - A request is accepted when req_valid[i] && req_ready[i]. On accept: latch operands, op, half, tag and src into the alu_* and tag registers; load the cycle counter with MUL_LAT-1 for op 4'b0111, else 0; go to EXEC.
- Arbitration:
  - With a single valid requester, it wins.
  - With both valid, the requester other than the last winner wins. The pointer updates only on accept.
  - After reset, requester 0 has priority.
- EXEC:
  - Hold the alu_* registers stable.
  - While the counter is nonzero, decrement it.
  - When the counter is 0: capture alu_out→res_data and alu_zero→res_zero, then go to HOLD.
  - Illegal op (4'b1001–4'b1111): do not sample the ALU; res_data=0, res_zero=1, res_err=1. This takes the 1-cycle EXEC path.
- HOLD:
  - res_valid=1; all res_* outputs stable.
  - On res_ready: return to IDLE next cycle and clear res_valid.
- Requesters must hold valid and payload until accepted. A valid that drops before accept is legal and simply loses arbitration.
- req_ready is 0 in EXEC and HOLD. No queueing.

## Timing
- Reset values:
  - state=IDLE; req_ready=0 except as granted combinationally in IDLE.
  - res_valid=0, res_data=0, res_zero=0, res_err=0, res_tag=0, res_src=0.
  - alu_a=0, alu_b=0, alu_ctr=0, alu_half=0; pointer favors requester 0.
- Accept at edge of cycle 0 → EXEC in cycle 1 → res_valid high from cycle 1+L, where L=1 for non-multiply/illegal ops and L=MUL_LAT for multiply.
- With res_ready held high, the next accept is possible in cycle 2+L. Peak throughput is 1 op per L+2 cycles.
- res_ready asserted while res_valid=0 is ignored.
- Reset asserted mid-EXEC or mid-HOLD: the in-flight op is discarded and all outputs go to reset values asynchronously. No result is produced after reset releases.
- MUL_LAT=1: multiply timing is identical to the other ops.

## Structure
- Shared package spu_alu_pkg holds:
  - alu_op_e: SUB=0, ADD=1, AND=2, OR=3, XOR=4, SHL=5, SHR=6, MUL=7, CEQ=8
  - ALU_OP_MAX=8
  - sched_state_e {IDLE, EXEC, HOLD}
  - default MUL_LAT
- One natural sub-module: spu_rr_arb2, a 2-way round-robin arbiter. Ports: clk, rst_n, req[1:0], advance, grant[1:0]. It owns the pointer register; advance is asserted on accept.
- The ALU itself is instantiated by the parent, not inside this block.

## Test plan
- Single add: req0 a=100000, b=100000, op=0001, full, tag=3. Required: accept in cycle 0; res_valid in cycle 2 with res_data=200000, res_zero=0, res_tag=3, res_src=0.
- Multiply, MUL_LAT=4: req1 a=10000, b=500, op=0111. Required: res_valid exactly in cycle 5; res_data=5000000; alu_* stable for cycles 1–4.
- Contention: both valid every cycle, res_ready=1. Required: grants alternate 0,1,0,1 starting with 0 after reset; no requester is accepted twice in a row.
- Backpressure: after a CEQ with a=1000, b=500 (res_data=0, res_zero=1), hold res_ready=0 for 5 cycles. Required: res_* stable, req_ready=0 throughout; IDLE one cycle after res_ready=1.
- Illegal op 4'b1010. Required: res_valid in cycle 2 with res_err=1, res_data=0, res_zero=1.
- Reset mid-multiply: drop rst_n in cycle 3. Required: res_valid=0 immediately; after release, no result appears, and req0 wins a simultaneous request.

Source files
------------

// File: rtl/spu_alu_pkg.sv
// Shared types and constants for the SPU ALU scheduler.
package spu_alu_pkg;

    // ALU control codes understood by the quadword ALU; codes above CEQ are illegal.
    typedef enum logic [3:0] {
        SUB = 4'd0,
        ADD = 4'd1,
        AND = 4'd2,
        OR  = 4'd3,
        XOR = 4'd4,
        SHL = 4'd5,
        SHR = 4'd6,
        MUL = 4'd7,
        CEQ = 4'd8
    } alu_op_e;

    localparam logic [3:0] ALU_OP_MAX = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } sched_state_e;

    localparam int MUL_LAT_DEF = 4;

endpackage

// File: rtl/spu_rr_arb2.sv
// Two-way round-robin arbiter. The pointer remembers the last winner and
// moves only when the parent reports an accept.
module spu_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_q;
    logic last_d;

    // Lone requester always wins; a contested grant goes to the one that did not win last.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_q ? 2'b01 : 2'b10;
        end
    end

    // Next pointer follows the winner only on an actual accept.
    always_comb begin
        last_d = last_q;
        if (advance && (grant != 2'b00)) begin
            last_d = grant[1];
        end
    end

    // Pointer register; reset as though requester 1 won last so requester 0 leads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/spu_alu_sched.sv
// Shares one quadword ALU between two requesters: round-robin accept,
// registered operands, fixed multiply latency, held result until consumed.
module spu_alu_sched
    import spu_alu_pkg::*;
#(
    parameter int DATA_W  = 128,
    parameter int TAG_W   = 4,
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [DATA_W-1:0] req_b0,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [DATA_W-1:0] req_b1,
    input  logic [3:0]        req_op0,
    input  logic [3:0]        req_op1,
    input  logic              req_half0,
    input  logic              req_half1,
    input  logic [TAG_W-1:0]  req_tag0,
    input  logic [TAG_W-1:0]  req_tag1,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_ctr,
    output logic              alu_half,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_zero,
    output logic              res_err,
    output logic [TAG_W-1:0]  res_tag,
    output logic              res_src
);

    // Counter only needs to reach MUL_LAT-1.
    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);

    sched_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [3:0]        alu_ctr_q, alu_ctr_d;
    logic              alu_half_q, alu_half_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              src_q, src_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic              res_zero_q, res_zero_d;
    logic              res_err_q, res_err_d;
    logic [1:0]        grant;
    logic              accept;
    logic              sel;
    logic [3:0]        op_sel;

    spu_rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .advance (accept),
        .grant   (grant)
    );

    // Next state, operand capture on accept, result capture at end of EXEC.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_ctr_d  = alu_ctr_q;
        alu_half_d = alu_half_q;
        tag_d      = tag_q;
        src_d      = src_q;
        res_data_d = res_data_q;
        res_zero_d = res_zero_q;
        res_err_d  = res_err_q;
        req_ready  = 2'b00;
        accept     = 1'b0;
        sel        = grant[1];
        op_sel     = grant[1] ? req_op1 : req_op0;

        case (state_q)
            IDLE: begin
                req_ready = grant;
                if ((req_valid & grant) != 2'b00) begin
                    accept     = 1'b1;
                    alu_a_d    = sel ? req_a1 : req_a0;
                    alu_b_d    = sel ? req_b1 : req_b0;
                    alu_ctr_d  = op_sel;
                    alu_half_d = sel ? req_half1 : req_half0;
                    tag_d      = sel ? req_tag1 : req_tag0;
                    src_d      = sel;
                    cnt_d      = (op_sel == MUL) ? MUL_CNT : '0;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // Illegal codes never look at the ALU output.
                    if (alu_ctr_q > ALU_OP_MAX) begin
                        res_data_d = '0;
                        res_zero_d = 1'b1;
                        res_err_d  = 1'b1;
                    end else begin
                        res_data_d = alu_out;
                        res_zero_d = alu_zero;
                        res_err_d  = 1'b0;
                    end
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // All state, including operand and result registers, clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_ctr_q  <= '0;
            alu_half_q <= 1'b0;
            tag_q      <= '0;
            src_q      <= 1'b0;
            res_data_q <= '0;
            res_zero_q <= 1'b0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_ctr_q  <= alu_ctr_d;
            alu_half_q <= alu_half_d;
            tag_q      <= tag_d;
            src_q      <= src_d;
            res_data_q <= res_data_d;
            res_zero_q <= res_zero_d;
            res_err_q  <= res_err_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_ctr   = alu_ctr_q;
    assign alu_half  = alu_half_q;
    assign res_valid = (state_q == HOLD);
    assign res_data  = res_data_q;
    assign res_zero  = res_zero_q;
    assign res_err   = res_err_q;
    assign res_tag   = tag_q;
    assign res_src   = src_q;

endmodule
